// File: rtl/spi_eeprom_seq_if.sv
// Request/response and SPI-master bundle for the EEPROM sequencer.
// The slave modport is the sequencer's view; master is the requester plus SPI master.
interface spi_eeprom_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [31:0] spi_din;
  logic        spi_en;
  logic [1:0]  spi_freq;
  logic [31:0] spi_dout;
  logic        spi_done;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, spi_dout, spi_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, spi_din, spi_en, spi_freq
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, spi_dout, spi_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, spi_din, spi_en, spi_freq
  );
endinterface

// File: rtl/spi_eeprom_seq.sv
// Byte read/write sequencer for a 25xx-style SPI EEPROM behind a 32-bit frame master.
// Writes run WREN, WRITE, then RDSR polling until WIP clears or the poll budget runs out.
module spi_eeprom_seq #(
  parameter logic [1:0] FREQ     = 2'b00,
  parameter int         FRAME_TO = 4096,
  parameter int         POLL_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  spi_eeprom_seq_if.slave  bus
);
  localparam int TW = $clog2(FRAME_TO + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WREN, S_WR, S_POLL, S_RESP} state_t;
  // Each frame state walks LOAD (din valid, en low) -> ACTIVE (en high) -> DONE (en low).
  typedef enum logic [1:0] {P_LOAD, P_ACTIVE, P_DONE} phase_t;

  state_t        r_state, w_state_nxt;
  phase_t        r_phase, w_phase_nxt;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_poll;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata, r_rx, r_rdata;
  logic          r_wip, r_err;
  logic          w_in_frame, w_active, w_done, w_timeout, w_to_resp;
  logic [31:0]   w_din;

  assign w_in_frame = (r_state == S_RD) || (r_state == S_WREN) ||
                      (r_state == S_WR) || (r_state == S_POLL);
  assign w_active   = w_in_frame && (r_phase == P_ACTIVE);
  assign w_done     = w_active && bus.spi_done;
  assign w_timeout  = w_active && !bus.spi_done && (r_timer == TW'(FRAME_TO - 1));
  assign w_to_resp  = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = bus.req_write ? S_WREN : S_RD;
          w_phase_nxt = P_LOAD;
        end
      end
      S_RD, S_WREN, S_WR, S_POLL: begin
        case (r_phase)
          P_LOAD:   w_phase_nxt = P_ACTIVE;
          P_ACTIVE: begin
            if (bus.spi_done) begin
              w_phase_nxt = P_DONE;
            end else if (w_timeout) begin
              w_state_nxt = S_RESP;
              w_phase_nxt = P_LOAD;
            end
          end
          default: begin
            // DONE doubles as the first low cycle of the mandatory two-cycle gap.
            w_phase_nxt = P_LOAD;
            case (r_state)
              S_WREN:  w_state_nxt = S_WR;
              S_WR:    w_state_nxt = S_POLL;
              S_POLL:  w_state_nxt = (!r_wip || r_poll == PW'(POLL_MAX)) ? S_RESP : S_POLL;
              default: w_state_nxt = S_RESP;
            endcase
          end
        endcase
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_din = 32'h0;
    case (r_state)
      S_RD:    w_din = {8'h03, r_addr, 8'h00};
      S_WREN:  w_din = {8'h06, 24'h0};
      S_WR:    w_din = {8'h02, r_addr, r_wdata};
      S_POLL:  w_din = {8'h05, 24'h0};
      default: w_din = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= P_LOAD;
      r_timer <= '0;
      r_poll  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_wip   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_timer <= w_active ? r_timer + 1'b1 : '0;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_write ? bus.req_wdata : 8'h00;
      end
      if (w_done) begin
        if (r_state == S_RD) r_rx <= bus.spi_dout[7:0];
        if (r_state == S_WR) r_poll <= '0;
        if (r_state == S_POLL) begin
          r_wip <= bus.spi_dout[16];
          if (bus.spi_dout[16]) r_poll <= r_poll + 1'b1;
        end
      end
      if (w_to_resp) begin
        r_rdata <= (r_state == S_RD && !w_timeout) ? r_rx : 8'h00;
        r_err   <= w_timeout || (r_state == S_POLL && r_wip);
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.spi_din   = w_din;
  assign bus.spi_en    = w_active;
  assign bus.spi_freq  = FREQ;
endmodule

// File: tb/tb_spi_eeprom_seq.sv
// Self-checking bench: behavioural SPI master, frame/response scoreboards, scenario tasks.
module tb_spi_eeprom_seq;
  localparam logic [1:0] FREQ     = 2'b10;
  localparam int         FRAME_TO = 40;
  localparam int         POLL_MAX = 5;
  localparam logic [31:0] F_WREN  = 32'h0600_0000;
  localparam logic [31:0] F_RDSR  = 32'h0500_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_eeprom_seq_if bus ();

  spi_eeprom_seq #(.FREQ(FREQ), .FRAME_TO(FRAME_TO), .POLL_MAX(POLL_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_frames = 0;
  int n_rsp = 0;
  int t_done = 0, t_rsp = 0, t_rise = 0, t_fall = 0;
  logic [31:0] q_frame[$];
  logic [8:0]  q_rsp[$];   // {err, rdata}

  // Master model controls (written only by the test sequence)
  int          m_lat = 3;
  bit          m_hang = 1'b0;
  logic [31:0] m_rd_word = 32'h0;
  bit          m_mix = 1'b0;
  int          m_wip_frames = 0;
  int          m_stray_req = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural SPI master: answers each enabled frame after m_lat cycles.
  initial begin : master_model
    bit          busy;
    int          cnt, rdsr_cnt, stray_ack;
    logic [7:0]  op;
    logic [7:0]  mix;
    busy = 1'b0; cnt = 0; rdsr_cnt = 0; stray_ack = 0; op = 8'h00;
    bus.spi_done = 1'b0;
    bus.spi_dout = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.spi_done = 1'b0;
      if (m_stray_req != stray_ack) begin
        stray_ack = m_stray_req;
        bus.spi_dout = 32'h0000_00C3;
        bus.spi_done = 1'b1;
      end else if (bus.spi_en === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          op = bus.spi_din[31:24];
          mix = m_mix ? bus.spi_din[15:8] : 8'h00;
          if (op == 8'h06) rdsr_cnt = 0;
          if (op == 8'h05) rdsr_cnt++;
        end
        cnt++;
        if (!m_hang && cnt == m_lat) begin
          case (op)
            8'h03:   bus.spi_dout = m_rd_word ^ {24'h0, mix};
            8'h05:   bus.spi_dout = (rdsr_cnt <= m_wip_frames) ? 32'h0001_0000 : 32'hFFFE_FFFF;
            default: bus.spi_dout = 32'hDEAD_BEEF;
          endcase
          bus.spi_done = 1'b1;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Monitor: frame scoreboard, inter-frame gap, din stability, response scoreboard.
  logic        mon_prev_en = 1'b0;
  int          mon_low = 100;
  logic [31:0] mon_held = 32'h0;
  bit          mon_changed = 1'b0;
  logic [31:0] exp_f;
  logic [8:0]  exp_r;

  initial forever begin
    @(negedge clk);
    if (bus.spi_done === 1'b1) t_done = cyc;
    if (bus.spi_en === 1'b1 && !mon_prev_en) begin
      n_frames++;
      t_rise = cyc;
      mon_held = bus.spi_din;
      mon_changed = 1'b0;
      checks++;
      if (mon_low < 2) begin
        failures++;
        $display("FAIL frame_gap: spi_en low for %0d cycles, required >= 2", mon_low);
      end
      checks++;
      if (q_frame.size() == 0) begin
        failures++;
        $display("FAIL frame_unexpected: spi_din=%h, required no frame", bus.spi_din);
      end else begin
        exp_f = q_frame.pop_front();
        if (bus.spi_din !== exp_f) begin
          failures++;
          $display("FAIL frame_word: spi_din=%h, required %h", bus.spi_din, exp_f);
        end
      end
    end else if (bus.spi_en === 1'b1) begin
      if (bus.spi_din !== mon_held) mon_changed = 1'b1;
    end else if (mon_prev_en) begin
      t_fall = cyc;
      checks++;
      if (mon_changed) begin
        failures++;
        $display("FAIL din_stable: spi_din changed while spi_en=1 (held %h), required stable", mon_held);
      end
    end
    mon_low = (bus.spi_en === 1'b1) ? 0 : mon_low + 1;
    mon_prev_en = (bus.spi_en === 1'b1);
    if (bus.rsp_valid === 1'b1) begin
      n_rsp++;
      t_rsp = cyc;
      checks++;
      if (q_rsp.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rdata=%h err=%b, required no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        exp_r = q_rsp.pop_front();
        if (bus.rsp_rdata !== exp_r[7:0]) begin
          failures++;
          $display("FAIL rsp_rdata: got %h, required %h", bus.rsp_rdata, exp_r[7:0]);
        end
        checks++;
        if (bus.rsp_err !== exp_r[8]) begin
          failures++;
          $display("FAIL rsp_err: got %b, required %b", bus.rsp_err, exp_r[8]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Tasks start and end at posedge+1.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    int n = 0;
    while (n_rsp < target && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL %s_rsp_wait: responses=%0d, required %0d", name, n_rsp, target);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); end
    checks++; if (bus.spi_en !== 1'b0) begin failures++; $display("FAIL rst_spi_en: got %b, required 0", bus.spi_en); end
    checks++; if (bus.spi_din !== 32'h0) begin failures++; $display("FAIL rst_spi_din: got %h, required 0", bus.spi_din); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin failures++; $display("FAIL rst_rsp_rdata: got %h, required 00", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err: got %b, required 0", bus.rsp_err); end
    checks++; if (bus.spi_freq !== FREQ) begin failures++; $display("FAIL rst_spi_freq: got %b, required %b", bus.spi_freq, FREQ); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read();
    int base;
    m_lat = 3; m_mix = 1'b0; m_rd_word = 32'h0000_00A5;
    base = n_rsp;
    q_frame.push_back(32'h0312_3400);
    q_rsp.push_back({1'b0, 8'hA5});
    issue(1'b0, 16'h1234, 8'h00);
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL read_ready_drop: req_ready=%b, required 0", bus.req_ready); end
    wait_rsp(base + 1, "read");
    checks++;
    if (t_rsp - t_done != 2) begin failures++; $display("FAIL read_latency: %0d cycles done->rsp, required 2", t_rsp - t_done); end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL read_pulse: rsp_valid=%b req_ready=%b, required 0/1", bus.rsp_valid, bus.req_ready);
    end
    m_rd_word = 32'h5A5A_5A3C;
    q_frame.push_back(32'h03FF_FF00);
    q_rsp.push_back({1'b0, 8'h3C});
    issue(1'b0, 16'hFFFF, 8'h00);
    wait_rsp(base + 2, "read_top");
    checks++;
    if (bus.rsp_rdata !== 8'h3C) begin failures++; $display("FAIL read_hold: rdata=%h, required 3C", bus.rsp_rdata); end
  endtask

  task automatic test_write();
    int base;
    m_lat = 4; m_wip_frames = 3;
    base = n_rsp;
    q_frame.push_back(F_WREN);
    q_frame.push_back(32'h0200_105A);
    repeat (4) q_frame.push_back(F_RDSR);
    q_rsp.push_back({1'b0, 8'h00});
    issue(1'b1, 16'h0010, 8'h5A);
    wait_rsp(base + 1, "write");
    checks++;
    if (q_frame.size() != 0) begin failures++; $display("FAIL write_frames: %0d frames missing, required 0", q_frame.size()); end
  endtask

  task automatic test_timeout();
    int base;
    m_hang = 1'b1;
    base = n_rsp;
    q_frame.push_back(32'h0300_4200);
    q_rsp.push_back({1'b1, 8'h00});
    issue(1'b0, 16'h0042, 8'h00);
    wait_rsp(base + 1, "timeout");
    checks++;
    if (t_fall - t_rise != FRAME_TO) begin failures++; $display("FAIL timeout_len: spi_en high %0d cycles, required %0d", t_fall - t_rise, FRAME_TO); end
    checks++;
    if (t_rsp != t_fall) begin failures++; $display("FAIL timeout_rsp_cycle: rsp at %0d, fall at %0d, required equal", t_rsp, t_fall); end
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready: got %b, required 1", bus.req_ready); end
    m_hang = 1'b0;
  endtask

  task automatic test_stray_done();
    int base, nf;
    base = n_rsp; nf = n_frames;
    m_stray_req++;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_rsp != base || n_frames != nf) begin failures++; $display("FAIL stray_done: rsp=%0d frames=%0d, required %0d/%0d", n_rsp, n_frames, base, nf); end
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL stray_hold: err=%b rdata=%h, required 1/00", bus.rsp_err, bus.rsp_rdata);
    end
  endtask

  task automatic test_poll_overrun();
    int base;
    m_lat = 2; m_wip_frames = 1000;
    base = n_rsp;
    q_frame.push_back(F_WREN);
    q_frame.push_back(32'h0200_7FEE);
    repeat (POLL_MAX) q_frame.push_back(F_RDSR);
    q_rsp.push_back({1'b1, 8'h00});
    issue(1'b1, 16'h007F, 8'hEE);
    wait_rsp(base + 1, "overrun");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q_frame.size() != 0) begin failures++; $display("FAIL overrun_frames: %0d frames missing, required 0", q_frame.size()); end
    m_wip_frames = 0;
  endtask

  task automatic test_reset_mid_frame();
    int base, nf, n;
    m_lat = 20;
    base = n_rsp; nf = n_frames; n = 0;
    q_frame.push_back(F_WREN);
    q_frame.push_back(32'h0200_2211);
    q_rsp.push_back({1'b0, 8'h00});
    issue(1'b1, 16'h0022, 8'h11);
    while (n_frames < nf + 2 && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL wr_frame_wait: frames=%0d, required %0d", n_frames - nf, 2); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q_frame.delete();
    q_rsp.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.spi_en !== 1'b0) begin failures++; $display("FAIL rst_mid_en: spi_en=%b, required 0", bus.spi_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (n_rsp != base) begin failures++; $display("FAIL rst_mid_rsp: responses=%0d, required %0d", n_rsp, base); end
    m_lat = 3; m_rd_word = 32'h0000_0077;
    q_frame.push_back(32'h030B_EE00);
    q_rsp.push_back({1'b0, 8'h77});
    issue(1'b0, 16'h0BEE, 8'h00);
    wait_rsp(base + 1, "rst_then_read");
  endtask

  task automatic test_back_to_back();
    int base, nf;
    m_lat = 6; m_mix = 1'b1; m_rd_word = 32'h0000_0080; m_wip_frames = 0;
    base = n_rsp; nf = n_frames;
    q_frame.push_back(32'h0300_AA00);
    q_rsp.push_back({1'b0, 8'h80 ^ 8'hAA});
    issue(1'b0, 16'h00AA, 8'h00);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0BAD; bus.req_wdata = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_rsp(base + 1, "busy");
    checks++;
    if (n_frames != nf + 1) begin failures++; $display("FAIL busy_ignore: %0d frames, required 1", n_frames - nf); end
    m_lat = 2;
    q_frame.push_back(32'h0301_0100);
    q_rsp.push_back({1'b0, 8'h81});
    q_frame.push_back(F_WREN);
    q_frame.push_back(32'h0202_0277);
    q_frame.push_back(F_RDSR);
    q_rsp.push_back({1'b0, 8'h00});
    q_frame.push_back(32'h0303_0300);
    q_rsp.push_back({1'b0, 8'h83});
    issue(1'b0, 16'h0101, 8'h00);
    issue(1'b1, 16'h0202, 8'h77);
    issue(1'b0, 16'h0303, 8'h00);
    wait_rsp(base + 4, "b2b");
    checks++;
    if (q_frame.size() != 0 || q_rsp.size() != 0) begin
      failures++; $display("FAIL b2b_drain: frames=%0d rsps=%0d left, required 0/0", q_frame.size(), q_rsp.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_stray_done();
    test_poll_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_eeprom_seq.md
SPI_EEPROM_SEQ -- requirements
Module: spi_eeprom_seq

Interface
REQ-001 Parameter FREQ, default 2'b00, SCK rate code driven constantly on spi_freq.
REQ-002 Parameter FRAME_TO, default 4096, max clk cycles from spi_en rise to spi_done before a frame is declared failed.
REQ-003 Parameter POLL_MAX, default 255, max RDSR frames while waiting for write completion.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  user request present.
REQ-007 req_ready  out  1  block idle, accepts request this cycle.
REQ-008 req_write  in  1  1 = byte write, 0 = byte read.
REQ-009 req_addr  in  16  EEPROM byte address.
REQ-010 req_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-cycle pulse, request finished.
REQ-012 rsp_rdata  out  8  read data, valid with rsp_valid (0 for writes).
REQ-013 rsp_err  out  1  valid with rsp_valid; 1 = frame timeout or poll overrun.
REQ-014 spi_din  out  32  frame word to SPI master, MSB sent first.
REQ-015 spi_en  out  1  frame enable to SPI master.
REQ-016 spi_freq  out  2  SCK rate code to SPI master.
REQ-017 spi_dout  in  32  word received by SPI master.
REQ-018 spi_done  in  1  one-cycle successful-transfer pulse from SPI master.

Function
REQ-019 Frame formats: READ {8'h03, addr, 8'h00}; WREN {8'h06, 24'h0}; WRITE {8'h02, addr, wdata}; RDSR {8'h05, 24'h0}.
REQ-020 States: IDLE, RD, WREN, WR, POLL, RESP.
REQ-021 IDLE: req_ready=1; on req_valid latch req_write/addr/wdata, req_ready drops next cycle; go RD (read) or WREN (write).
REQ-022 Frame protocol, each of RD/WREN/WR/POLL: spi_din loaded on state entry and held stable until spi_en is deasserted; spi_en asserted one cycle after spi_din is loaded; held high until spi_done or timeout.
REQ-023 After every frame, spi_en is low for at least 2 clk cycles before the next assertion, so the master restarts its frame counter.
REQ-024 Frame timer: starts at 0 on spi_en rise; reaching FRAME_TO without spi_done -> spi_en low, rsp_err=1, go RESP.
REQ-025 RD: on spi_done capture spi_dout[7:0] into rsp_rdata -> RESP.
REQ-026 WREN: on spi_done -> WR; WR: on spi_done -> POLL with poll counter cleared.
REQ-027 POLL: on spi_done check WIP = spi_dout[16]; WIP=0 -> RESP, rsp_err=0; WIP=1 -> increment poll counter, issue another RDSR.
REQ-028 Poll overrun: if the counter reaches POLL_MAX with WIP still 1 -> rsp_err=1, go RESP.
REQ-029 RESP: rsp_valid=1 for exactly one cycle -> IDLE; rsp_rdata/rsp_err hold until the next RESP.
REQ-030 spi_done while spi_en low, or while in IDLE/RESP, is ignored.
REQ-031 req_valid while req_ready=0 is ignored; no queuing.
REQ-032 Latency for a read, frame time T: rsp_valid exactly 2 clk after spi_done.

Reset
REQ-033 On rst: state IDLE, req_ready=1, spi_en=0, spi_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timers and counters 0.
REQ-034 rst mid-frame drops spi_en in the same cycle; the request is abandoned and no rsp_valid is issued.
REQ-035 spi_freq=FREQ at all times, including during reset.

Verification
REQ-036 Read addr 16'h1234, master model returns dout 32'h000000A5 -> spi_din=32'h031234_00, single rsp_valid, rsp_rdata=8'hA5, rsp_err=0.
REQ-037 Write addr 16'h0010, data 8'h5A, WIP=1 for 3 RDSR frames then 0 -> frame sequence 32'h06000000, 32'h0200105A, 4x 32'h05000000; rsp_err=0.
REQ-038 Read with spi_done never returned -> spi_en falls at FRAME_TO; rsp_valid with rsp_err=1; req_ready=1 the following cycle.
REQ-039 Write with WIP stuck at 1 -> exactly POLL_MAX RDSR frames, then rsp_err=1.
REQ-040 rst asserted during the WR frame -> spi_en=0 next edge; no rsp_valid; a new read is then accepted and completes correctly.
REQ-041 Between any two frames, spi_en low for at least 2 cycles; spi_din never changes while spi_en=1; a stray spi_done while idle produces no response.
